phone_line_ctrl: RTL and testbench

Parametrised next-generation subscriber line controller for the phone-system model.
- Collects a multi-digit dialed number and requests a connection from the exchange with a req/ack handshake.
- Handles incoming ringing, ring and dial timeouts, remote hang-up and a busy-tone state.
- One instance per subscriber line; the exchange instantiates one controller per line.

---
 rtl/phone_pkg.sv | 21 ++
 rtl/phone_line_ctrl_if.sv | 34 +++
 rtl/phone_timeout_ctr.sv | 28 ++
 rtl/phone_line_ctrl.sv | 147 ++++++++++++++
 tb/tb_phone_line_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/phone_pkg.sv
// Shared types for the subscriber line controller: state encoding, default digit width, timer sizing.
package phone_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DIALING = 3'd1,
        ST_CALLING = 3'd2,
        ST_RINGING = 3'd3,
        ST_TALKING = 3'd4,
        ST_BUSY    = 3'd5
    } phone_state_t;

    localparam int DIGIT_W = 4;

    function automatic int timer_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/phone_line_ctrl_if.sv
// Line-side signal bundle between the exchange (master) and one line controller (slave).
interface phone_line_ctrl_if #(
    parameter int ID_W   = 4,
    parameter int DIGITS = 2
);
    logic [ID_W-1:0]        id;
    logic                   off_hook;
    logic [ID_W-1:0]        digit;
    logic                   digit_valid;
    logic                   ring_in;
    logic                   dial_ack;
    logic                   callee_busy;
    logic                   remote_answer;
    logic                   remote_hangup;
    logic                   dial_req;
    logic [ID_W*DIGITS-1:0] dial_num;
    logic [ID_W-1:0]        caller_id;
    logic [2:0]             state;
    logic                   free;
    logic                   ringer;
    logic                   busy_tone;

    modport master (
        output id, off_hook, digit, digit_valid, ring_in, dial_ack, callee_busy,
               remote_answer, remote_hangup,
        input  dial_req, dial_num, caller_id, state, free, ringer, busy_tone
    );

    modport slave (
        input  id, off_hook, digit, digit_valid, ring_in, dial_ack, callee_busy,
               remote_answer, remote_hangup,
        output dial_req, dial_num, caller_id, state, free, ringer, busy_tone
    );
endinterface

// File: rtl/phone_timeout_ctr.sv
// Saturating cycle counter; done flags the cycle that completes `limit` counted cycles.
// Zero latency on done (combinational from count); clear has priority over enable.
module phone_timeout_ctr #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         done
);
    logic [W-1:0] count;
    logic [W:0]   count_inc;

    assign count_inc = {1'b0, count} + {{W{1'b0}}, 1'b1};
    assign done      = count_inc >= {1'b0, limit};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != {W{1'b1}})) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end
    end
endmodule

// File: rtl/phone_line_ctrl.sv
// Subscriber line controller (dial, request, ring, talk, timeouts); outputs registered, one edge after condition.
// Optional PHONE_REDIAL_EN: all-ones first digit redials the last called number.
module phone_line_ctrl
    import phone_pkg::*;
#(
    parameter int ID_W         = DIGIT_W,
    parameter int DIGITS       = 2,
    parameter int DIAL_TIMEOUT = 8,
    parameter int RING_TIMEOUT = 5
) (
    input  logic             clock,
    input  logic             reset,
    phone_line_ctrl_if.slave line
);
    localparam int NUM_W = ID_W * DIGITS;
    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam int TMR_W = timer_w(DIAL_TIMEOUT, RING_TIMEOUT);

    phone_state_t     st;
    logic             req_q;
    logic [NUM_W-1:0] num_q;
    logic [NUM_W-1:0] shifted;
    logic [CNT_W-1:0] cnt;
    logic             timed;
    logic             tmo;
    logic             tmr_clr;
    logic             tmr_done;
    logic [TMR_W-1:0] tmr_limit;
    logic             last_digit;

`ifdef PHONE_REDIAL_EN
    logic [NUM_W-1:0] last_num;
    logic             last_vld;
    logic             redial_key;
    assign redial_key = (line.digit == {ID_W{1'b1}}) && (cnt == '0);
`endif

    assign shifted    = (num_q << ID_W) | NUM_W'(line.digit);
    assign last_digit = (cnt == CNT_W'(DIGITS - 1));

    // Timer only runs while waiting for a digit or for the far end to answer; any exit clears it.
    assign timed     = (st == ST_DIALING) || ((st == ST_CALLING) && !req_q);
    assign tmo       = timed && tmr_done;
    assign tmr_limit = (st == ST_DIALING) ? TMR_W'(DIAL_TIMEOUT) : TMR_W'(RING_TIMEOUT);
    assign tmr_clr   = !timed || !line.off_hook || tmo
                     || ((st == ST_DIALING) && line.digit_valid)
                     || ((st == ST_CALLING) && line.remote_answer);

    phone_timeout_ctr #(.W(TMR_W)) u_tmr (
        .clock  (clock),
        .reset  (reset),
        .clear  (tmr_clr),
        .enable (timed),
        .limit  (tmr_limit),
        .done   (tmr_done)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st    <= ST_IDLE;
            req_q <= 1'b0;
            num_q <= '0;
            cnt   <= '0;
`ifdef PHONE_REDIAL_EN
            last_num <= '0;
            last_vld <= 1'b0;
`endif
        end else if ((st != ST_IDLE) && (st != ST_RINGING) && !line.off_hook) begin
            // Ringing is the one non-idle state where the handset is expected to be down.
            st    <= ST_IDLE;
            req_q <= 1'b0;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (line.ring_in) begin
                        st <= line.off_hook ? ST_TALKING : ST_RINGING;
                    end else if (line.off_hook) begin
                        st    <= ST_DIALING;
                        num_q <= '0;
                        cnt   <= '0;
                    end
                end
                ST_DIALING: begin
                    if (line.digit_valid) begin
`ifdef PHONE_REDIAL_EN
                        if (redial_key) begin
                            if (last_vld) begin
                                num_q <= last_num;
                                st    <= ST_CALLING;
                                req_q <= 1'b1;
                            end
                        end else
`endif
                        begin
                            num_q <= shifted;
                            cnt   <= cnt + CNT_W'(1);
                            if (last_digit) begin
                                st    <= ST_CALLING;
                                req_q <= 1'b1;
`ifdef PHONE_REDIAL_EN
                                last_num <= shifted;
                                last_vld <= 1'b1;
`endif
                            end
                        end
                    end else if (tmo) begin
                        st <= ST_BUSY;
                    end
                end
                ST_CALLING: begin
                    if (req_q) begin
                        if (line.dial_ack) begin
                            req_q <= 1'b0;
                            if (line.callee_busy) st <= ST_BUSY;
                        end
                    end else if (line.remote_answer) begin
                        st <= ST_TALKING;
                    end else if (tmo) begin
                        st <= ST_BUSY;
                    end
                end
                ST_RINGING: begin
                    if (line.off_hook)      st <= ST_TALKING;
                    else if (!line.ring_in) st <= ST_IDLE;
                end
                ST_TALKING: begin
                    if (line.remote_hangup) st <= ST_BUSY;
                end
                ST_BUSY: begin
                    st <= ST_BUSY;
                end
                default: begin
                    st    <= ST_IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    assign line.state     = st;
    assign line.dial_req  = req_q;
    assign line.dial_num  = num_q;
    assign line.caller_id = req_q ? line.id : '0;
    assign line.free      = (st == ST_IDLE) && !line.off_hook;
    assign line.ringer    = (st == ST_RINGING);
    assign line.busy_tone = (st == ST_BUSY);
endmodule

// File: tb/tb_phone_line_ctrl.sv
// Bench for phone_line_ctrl: vector table through a scoreboard queue, plus async-reset and redial sequences.
module tb_phone_line_ctrl;
    localparam logic [3:0] LINE_ID = 4'hA;

    typedef struct {
        logic       oh, rin;
        logic [3:0] dg;
        logic       dv, ack, cb, ans, hup;
        logic [2:0] st;
        logic       req;
        logic [7:0] num;
    } vec_t;

    typedef struct packed {
        logic [2:0] st;
        logic       req;
        logic [7:0] num;
        logic       ring;
        logic       busy;
        logic       free;
        logic [3:0] cid;
    } obs_t;

    logic clock;
    logic reset;
    int   tests;
    int   fails;
    vec_t tbl[$];
    obs_t sb[$];

    phone_line_ctrl_if #(.ID_W(4), .DIGITS(2)) line ();

    phone_line_ctrl dut (
        .clock (clock),
        .reset (reset),
        .line  (line)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t V(input logic oh, input logic rin, input logic [3:0] dg,
                               input logic dv, input logic ack, input logic cb,
                               input logic ans, input logic hup,
                               input logic [2:0] st, input logic req, input logic [7:0] num);
        vec_t v;
        v.oh = oh; v.rin = rin; v.dg = dg; v.dv = dv; v.ack = ack; v.cb = cb;
        v.ans = ans; v.hup = hup; v.st = st; v.req = req; v.num = num;
        return v;
    endfunction

    // Expected observable outputs from the expected state and the handset level.
    function automatic obs_t expect_of(input logic [2:0] st, input logic req,
                                       input logic [7:0] num, input logic oh);
        obs_t e;
        e.st   = st;
        e.req  = req;
        e.num  = num;
        e.ring = (st == 3'd3);
        e.busy = (st == 3'd5);
        e.free = (st == 3'd0) && !oh;
        e.cid  = req ? LINE_ID : 4'h0;
        return e;
    endfunction

    task automatic check(input string name);
        obs_t got, exp;
        got.st   = line.state;
        got.req  = line.dial_req;
        got.num  = line.dial_num;
        got.ring = line.ringer;
        got.busy = line.busy_tone;
        got.free = line.free;
        got.cid  = line.caller_id;
        exp = sb.pop_front();
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got st=%0d req=%b num=%h ring=%b busy=%b free=%b cid=%h, want st=%0d req=%b num=%h ring=%b busy=%b free=%b cid=%h",
                     name, got.st, got.req, got.num, got.ring, got.busy, got.free, got.cid,
                     exp.st, exp.req, exp.num, exp.ring, exp.busy, exp.free, exp.cid);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        @(negedge clock);
        line.off_hook      = v.oh;
        line.ring_in       = v.rin;
        line.digit         = v.dg;
        line.digit_valid   = v.dv;
        line.dial_ack      = v.ack;
        line.callee_busy   = v.cb;
        line.remote_answer = v.ans;
        line.remote_hangup = v.hup;
        sb.push_back(expect_of(v.st, v.req, v.num, v.oh));
        @(posedge clock);
        #1;
        check(name);
    endtask

    task automatic dial_37(input string tag);
        apply(V(1,0,4'h0,0,0,0,0,0, 3'd1,0,8'h00), {tag, "_hook"});
        apply(V(1,0,4'h3,1,0,0,0,0, 3'd1,0,8'h03), {tag, "_d3"});
        apply(V(1,0,4'h7,1,0,0,0,0, 3'd2,1,8'h37), {tag, "_d7"});
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        line.id = LINE_ID;
        line.off_hook = 0; line.ring_in = 0; line.digit = 0; line.digit_valid = 0;
        line.dial_ack = 0; line.callee_busy = 0; line.remote_answer = 0; line.remote_hangup = 0;

        // Outgoing call: 3,7 -> ack -> answer two cycles later -> hangup -> on-hook
        tbl.push_back(V(1,0,4'h0,0,0,0,0,0, 3'd1,0,8'h00));
        tbl.push_back(V(1,0,4'h3,1,0,0,0,0, 3'd1,0,8'h03));
        tbl.push_back(V(1,0,4'h7,1,0,0,0,0, 3'd2,1,8'h37));
        tbl.push_back(V(1,0,4'h0,0,0,0,0,0, 3'd2,1,8'h37));
        tbl.push_back(V(1,0,4'h0,0,1,0,0,0, 3'd2,0,8'h37));
        tbl.push_back(V(1,0,4'h0,0,0,0,0,0, 3'd2,0,8'h37));
        tbl.push_back(V(1,0,4'h0,0,0,0,1,0, 3'd4,0,8'h37));
        tbl.push_back(V(1,0,4'h0,0,0,0,0,0, 3'd4,0,8'h37));
        tbl.push_back(V(1,0,4'h0,0,0,0,0,1, 3'd5,0,8'h37));
        tbl.push_back(V(0,0,4'h0,0,0,0,0,0, 3'd0,0,8'h37));
        // Dial timeout: busy on the 8th idle edge after the digit
        tbl.push_back(V(1,0,4'h0,0,0,0,0,0, 3'd1,0,8'h00));
        tbl.push_back(V(1,0,4'h5,1,0,0,0,0, 3'd1,0,8'h05));
        for (int i = 0; i < 7; i++) tbl.push_back(V(1,0,4'h0,0,0,0,0,0, 3'd1,0,8'h05));
        tbl.push_back(V(1,0,4'h0,0,0,0,0,0, 3'd5,0,8'h05));
        tbl.push_back(V(0,0,4'h0,0,0,0,0,0, 3'd0,0,8'h05));
        // Ring timeout: busy on the 5th edge after ack
        tbl.push_back(V(1,0,4'h0,0,0,0,0,0, 3'd1,0,8'h00));
        tbl.push_back(V(1,0,4'h3,1,0,0,0,0, 3'd1,0,8'h03));
        tbl.push_back(V(1,0,4'h7,1,0,0,0,0, 3'd2,1,8'h37));
        tbl.push_back(V(1,0,4'h0,0,1,0,0,0, 3'd2,0,8'h37));
        for (int i = 0; i < 4; i++) tbl.push_back(V(1,0,4'h0,0,0,0,0,0, 3'd2,0,8'h37));
        tbl.push_back(V(1,0,4'h0,0,0,0,0,0, 3'd5,0,8'h37));
        tbl.push_back(V(0,0,4'h0,0,0,0,0,0, 3'd0,0,8'h37));
        // Busy callee
        tbl.push_back(V(1,0,4'h0,0,0,0,0,0, 3'd1,0,8'h00));
        tbl.push_back(V(1,0,4'h3,1,0,0,0,0, 3'd1,0,8'h03));
        tbl.push_back(V(1,0,4'h7,1,0,0,0,0, 3'd2,1,8'h37));
        tbl.push_back(V(1,0,4'h0,0,1,1,0,0, 3'd5,0,8'h37));
        tbl.push_back(V(0,0,4'h0,0,0,0,0,0, 3'd0,0,8'h37));
        // Incoming: ring, answer, hang up; abandoned ring; answer-on-seize
        tbl.push_back(V(0,1,4'h0,0,0,0,0,0, 3'd3,0,8'h37));
        tbl.push_back(V(1,1,4'h0,0,0,0,0,0, 3'd4,0,8'h37));
        tbl.push_back(V(0,0,4'h0,0,0,0,0,0, 3'd0,0,8'h37));
        tbl.push_back(V(0,1,4'h0,0,0,0,0,0, 3'd3,0,8'h37));
        tbl.push_back(V(0,0,4'h0,0,0,0,0,0, 3'd0,0,8'h37));
        tbl.push_back(V(1,1,4'h0,0,0,0,0,0, 3'd4,0,8'h37));
        tbl.push_back(V(0,0,4'h0,0,0,0,0,0, 3'd0,0,8'h37));
        // On-hook in the same cycle as dial_ack
        tbl.push_back(V(1,0,4'h0,0,0,0,0,0, 3'd1,0,8'h00));
        tbl.push_back(V(1,0,4'h3,1,0,0,0,0, 3'd1,0,8'h03));
        tbl.push_back(V(1,0,4'h7,1,0,0,0,0, 3'd2,1,8'h37));
        tbl.push_back(V(0,0,4'h0,0,1,0,0,0, 3'd0,0,8'h37));

        #12;
        sb.push_back(expect_of(3'd0, 1'b0, 8'h00, 1'b0));
        check("reset_state");
        @(negedge clock);
        reset = 1'b0;

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Async reset in TALKING: outputs clear before any clock edge
        apply(V(1,1,4'h0,0,0,0,0,0, 3'd4,0,8'h37), "talk_setup");
        @(negedge clock);
        line.ring_in = 1'b0;
        #2 reset = 1'b1;
        #1;
        sb.push_back(expect_of(3'd0, 1'b0, 8'h00, 1'b1));
        check("async_reset_talking");
        line.off_hook = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        apply(V(0,0,4'h0,0,0,0,0,0, 3'd0,0,8'h00), "post_reset_idle");

        // Async reset with dial_req high: no request reappears afterwards
        dial_37("rst_call");
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        sb.push_back(expect_of(3'd0, 1'b0, 8'h00, 1'b1));
        check("async_reset_calling");
        line.off_hook = 1'b0;
        line.digit_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        apply(V(0,0,4'h0,0,0,0,0,0, 3'd0,0,8'h00), "no_req_glitch0");
        apply(V(0,0,4'h0,0,0,0,0,0, 3'd0,0,8'h00), "no_req_glitch1");

`ifdef PHONE_REDIAL_EN
        apply(V(1,0,4'h0,0,0,0,0,0, 3'd1,0,8'h00), "rd_hook_empty");
        apply(V(1,0,4'hF,1,0,0,0,0, 3'd1,0,8'h00), "rd_key_no_store");
        apply(V(1,0,4'h3,1,0,0,0,0, 3'd1,0,8'h03), "rd_d3");
        apply(V(1,0,4'h7,1,0,0,0,0, 3'd2,1,8'h37), "rd_d7");
        apply(V(0,0,4'h0,0,0,0,0,0, 3'd0,0,8'h37), "rd_onhook");
        apply(V(1,0,4'h0,0,0,0,0,0, 3'd1,0,8'h00), "rd_hook");
        apply(V(1,0,4'hF,1,0,0,0,0, 3'd2,1,8'h37), "rd_key_redial");
        apply(V(0,0,4'h0,0,0,0,0,0, 3'd0,0,8'h37), "rd_done");
`else
        apply(V(1,0,4'h0,0,0,0,0,0, 3'd1,0,8'h00), "f_hook");
        apply(V(1,0,4'hF,1,0,0,0,0, 3'd1,0,8'h0F), "f_plain_digit");
        apply(V(1,0,4'h1,1,0,0,0,0, 3'd2,1,8'hF1), "f_d1");
        apply(V(0,0,4'h0,0,0,0,0,0, 3'd0,0,8'hF1), "f_onhook");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
